// File: rtl/oifs_rx_interface.sv
// Receive side of the FTDI opto-isolated fast serial link: samples FSDO on FSCLK
// rising edges, deserialises {start, data, channel} frames and queues them in a FWFT FIFO.
module oifs_rx_interface #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              i_clk,
  input  logic              i_arst,
  input  logic              i_fsclk,
  input  logic              i_fsdo,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_channel,
  input  logic              i_ready,
  output logic              o_overrun,
  output logic              o_busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int unsigned EW = DATA_W + 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    CHAN
  } state_e;

  logic              r_fsclk_q, r_fsclk_d;
  logic              r_fsdo_q, r_fsdo_d;
  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [EW-1:0]     mem_q [DEPTH];
  logic [EW-1:0]     mem_d [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              overrun_q, overrun_d;

  logic sample;
  logic bit_in;
  logic push;
  logic push_ok;
  logic pop;
  logic full;

  // FSDO is taken from the registered copy, i.e. the value held during FSCLK low.
  assign sample = i_fsclk & ~r_fsclk_q;
  assign bit_in = r_fsdo_q;

  always_comb begin
    r_fsclk_d = i_fsclk;
    r_fsdo_d  = i_fsdo;
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    push      = 1'b0;
    case (state_q)
      IDLE: begin
        if (sample && !bit_in) begin
          state_d = DATA;
          cnt_d   = '0;
        end
      end
      DATA: begin
        if (sample) begin
          shreg_d = {bit_in, shreg_q[DATA_W-1:1]};
          if (cnt_q == LAST_BIT) begin
            state_d = CHAN;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      CHAN: begin
        if (sample) begin
          push    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A push into a full FIFO is dropped even if the head is popped in the same cycle.
  assign full    = (count_q == FULL_CNT);
  assign o_valid = (count_q != '0);
  assign pop     = o_valid & i_ready;
  assign push_ok = push & ~full;

  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = push & full;
    if (push_ok) begin
      mem_d[wr_ptr_q] = {bit_in, shreg_q};
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_ok, pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      r_fsclk_q <= 1'b0;
      r_fsdo_q  <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      shreg_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      r_fsclk_q <= r_fsclk_d;
      r_fsdo_q  <= r_fsdo_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign o_data    = mem_q[rd_ptr_q][DATA_W-1:0];
  assign o_channel = mem_q[rd_ptr_q][DATA_W];
  assign o_overrun = overrun_q;
  assign o_busy    = (state_q != IDLE);

endmodule

// File: tb/tb_oifs_rx_interface.sv
// Bench for oifs_rx_interface: frame table plus directed sequences, popped words
// checked against a scoreboard queue filled as frames are sent.
module tb_oifs_rx_interface;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 4;

  logic              clk = 1'b0;
  logic              i_arst;
  logic              i_fsclk;
  logic              i_fsdo;
  logic              o_valid;
  logic [DATA_W-1:0] o_data;
  logic              o_channel;
  logic              i_ready;
  logic              o_overrun;
  logic              o_busy;

  always #5 clk = ~clk;

  oifs_rx_interface #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) dut (
    .i_clk    (clk),
    .i_arst   (i_arst),
    .i_fsclk  (i_fsclk),
    .i_fsdo   (i_fsdo),
    .o_valid  (o_valid),
    .o_data   (o_data),
    .o_channel(o_channel),
    .i_ready  (i_ready),
    .o_overrun(o_overrun),
    .o_busy   (o_busy)
  );

  typedef struct {
    logic [7:0] data;
    logic       ch;
    logic       exp_ovr;
    logic [8:0] exp_head;
  } vec_t;

  int         n_vec  = 0;
  int         n_fail = 0;
  logic [8:0] exp_q[$];
  logic [8:0] mon_e;
  vec_t       vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!i_arst && o_valid && i_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL pop_unexpected: got 0x%0h expected no word", {o_channel, o_data});
      end else begin
        mon_e = exp_q.pop_front();
        chk("pop_word", 32'({o_channel, o_data}), 32'(mon_e));
      end
    end
  end

  task automatic cyc(input logic c, input logic d);
    i_fsclk = c;
    i_fsdo  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] data, input logic ch, input logic exp_ovr,
                            input int stall_at, input int nbits, input logic pop_at_s);
    logic [9:0] bits;
    logic       stall_bad;
    bits      = {ch, data, 1'b0};
    stall_bad = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      cyc(1'b0, bits[i]);
      if (i == 9 && pop_at_s) i_ready = 1'b1;
      cyc(1'b1, bits[i]);
      if (i == 0) chk("busy_rise", 32'(o_busy), 1);
      if (i == stall_at) begin
        repeat (30) begin
          cyc(1'b0, 1'($urandom));
          if (!o_busy) stall_bad = 1'b1;
        end
        chk("stall_busy", 32'(stall_bad), 0);
      end
    end
    if (nbits == 10) begin
      if (pop_at_s) i_ready = 1'b0;
      chk("ovr_pulse", 32'(o_overrun), 32'(exp_ovr));
      chk("busy_fall", 32'(o_busy), 0);
      chk("valid_latency", 32'(o_valid), 1);
      if (!exp_ovr) exp_q.push_back({ch, data});
      cyc(1'b0, 1'b1);
      chk("ovr_single", 32'(o_overrun), 0);
    end
  endtask

  task automatic drain();
    i_ready = 1'b1;
    repeat (DEPTH + 2) cyc(1'b0, 1'b1);
    i_ready = 1'b0;
    chk("drain_empty", 32'(o_valid), 0);
    chk("drain_sb", 32'(exp_q.size()), 0);
  endtask

  initial begin
    logic idle_bad;

    vecs[0] = '{8'h01, 1'b0, 1'b0, 9'h001};
    vecs[1] = '{8'h02, 1'b1, 1'b0, 9'h001};
    vecs[2] = '{8'h03, 1'b0, 1'b0, 9'h001};
    vecs[3] = '{8'h04, 1'b1, 1'b0, 9'h001};
    vecs[4] = '{8'h3C, 1'b1, 1'b1, 9'h001};

    i_arst  = 1'b1;
    i_fsclk = 1'b0;
    i_fsdo  = 1'b1;
    i_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(o_valid), 0);
    chk("rst_data", 32'(o_data), 0);
    chk("rst_channel", 32'(o_channel), 0);
    chk("rst_overrun", 32'(o_overrun), 0);
    chk("rst_busy", 32'(o_busy), 0);
    i_arst = 1'b0;
    cyc(1'b0, 1'b1);

    // single frame, consumer always ready
    i_ready = 1'b1;
    send_frame(8'hA5, 1'b1, 1'b0, -1, 10, 1'b0);
    chk("single_popped", 32'(o_valid), 0);
    chk("single_sb", 32'(exp_q.size()), 0);

    // fill to DEPTH then overrun, head must stay on the first word
    i_ready = 1'b0;
    for (int v = 0; v < 5; v++) begin
      send_frame(vecs[v].data, vecs[v].ch, vecs[v].exp_ovr, -1, 10, 1'b0);
      chk("table_head", 32'({o_channel, o_data}), 32'(vecs[v].exp_head));
      chk("table_valid", 32'(o_valid), 1);
    end
    drain();

    // idle line with FSCLK running
    i_ready  = 1'b1;
    idle_bad = 1'b0;
    repeat (100) begin
      cyc(1'b0, 1'b1);
      if (o_busy || o_valid) idle_bad = 1'b1;
      cyc(1'b1, 1'b1);
      if (o_busy || o_valid) idle_bad = 1'b1;
    end
    chk("idle_quiet", 32'(idle_bad), 0);

    // reset mid-frame with a word queued
    i_ready = 1'b0;
    send_frame(8'h99, 1'b1, 1'b0, -1, 10, 1'b0);
    send_frame(8'hB6, 1'b0, 1'b0, -1, 6, 1'b0);
    i_arst = 1'b1;
    #2;
    chk("mid_rst_valid", 32'(o_valid), 0);
    chk("mid_rst_data", 32'(o_data), 0);
    chk("mid_rst_channel", 32'(o_channel), 0);
    chk("mid_rst_overrun", 32'(o_overrun), 0);
    chk("mid_rst_busy", 32'(o_busy), 0);
    exp_q.delete();
    i_fsclk = 1'b0;
    i_fsdo  = 1'b1;
    @(posedge clk);
    #1;
    i_arst = 1'b0;
    cyc(1'b0, 1'b1);
    send_frame(8'h5A, 1'b0, 1'b0, -1, 10, 1'b0);
    chk("post_rst_head", 32'({o_channel, o_data}), 32'h05A);
    drain();

    // FSCLK stalled low mid-frame
    i_ready = 1'b1;
    send_frame(8'hC3, 1'b1, 1'b0, 4, 10, 1'b0);
    chk("stall_sb", 32'(exp_q.size()), 0);
    i_ready = 1'b0;

    // push completes in the same cycle the single queued word is popped
    send_frame(8'h11, 1'b0, 1'b0, -1, 10, 1'b0);
    send_frame(8'h77, 1'b1, 1'b0, -1, 10, 1'b1);
    chk("pushpop_head", 32'({o_channel, o_data}), 32'h177);
    chk("pushpop_valid", 32'(o_valid), 1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/oifs_rx_interface.md
# oifs_rx_interface

Receive-side serial stage for the FTDI opto-isolated fast serial link: deserialises frames arriving on FSDO, clocked by the FSCLK level that the top level already generates for the transmit side, into {channel, data} words. Sits between the FSDO pin and the downstream consumer and presents a valid/ready stream buffered by a small FIFO. Frames that arrive while the FIFO is full are dropped and flagged.

## Interface
- DATA_W, 8, payload bits per frame; a frame is 1 start + DATA_W data + 1 channel bit.
- DEPTH, 4, FIFO entries; power of two, ≥2.

- i_clk  input  1  system clock.
- i_arst  input  1  reset: asynchronous, active-high.
- i_fsclk  input  1  FSCLK level driven to the FTDI; synchronous to i_clk.
- i_fsdo  input  1  serial data from the FTDI; idle high.
- o_valid  output  1  FIFO head valid.
- o_data  output  DATA_W  head payload.
- o_channel  output  1  head source/channel bit.
- i_ready  input  1  consumer accepts head when o_valid & i_ready.
- o_overrun  output  1  one-cycle pulse, frame dropped because FIFO full.
- o_busy  output  1  high while a frame is being received (state ≠ IDLE).

## Operation
- Input registers: r_fsclk_q ← i_fsclk and r_fsdo_q ← i_fsdo, every cycle.
- Sample event S: cycle where i_fsclk = 1 and r_fsclk_q = 0. Sampled bit b = r_fsdo_q, i.e. FSDO as seen during the FSCLK low phase. No action on non-S cycles.
- FSM, 3 states:
  - IDLE: on S with b = 0 → DATA, bit counter ← 0. With b = 1, stay.
  - DATA: on S, shift b into the data register LSB-first. After the DATA_W-th bit (counter = DATA_W-1) → CHAN, else counter+1.
  - CHAN: on S, capture b as channel. Issue push of {b, data} → IDLE.
- Push: write occurs on the clock edge ending the CHAN S cycle. If the FIFO is full at that cycle, the frame is discarded, FIFO unchanged, and o_overrun = 1 in the following cycle only. A pop in the same cycle does not rescue a push to a full FIFO.
- FIFO: first-word-fall-through. o_valid = (count ≠ 0). o_data/o_channel = head entry. Pop on o_valid & i_ready.
  - Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
  - Simultaneous push and pop with count > 0: count unchanged, order preserved.
  - Simultaneous push and pop with count = 0: the pop is not possible because o_valid = 0, so only the push takes effect.
- When i_fsclk stops (held at either level), no S occurs and the FSM holds indefinitely. There is no timeout.
- No stop bit. A new start bit is accepted at the first S after CHAN.

## Timing
- Reset values: state IDLE, counter 0, FIFO empty, o_valid 0, o_data 0, o_channel 0, o_overrun 0, o_busy 0, r_fsclk_q 0, r_fsdo_q 1.
- Reset mid-frame: partial frame discarded and all FIFO contents lost. Reception restarts on the next start bit after release.
- Latency: o_valid rises 1 i_clk cycle after the CHAN S cycle when the FIFO is empty.
- With FSCLK toggling every i_clk, the frame period is 20 i_clk cycles (10 bits × 2). Sustained throughput is 1 word per 20 cycles.
- o_busy rises the cycle after the start-bit S and falls the cycle after the CHAN S.
- Outputs are registered or FIFO-memory driven. Nothing combinational from i_fsdo reaches any output. o_valid depends only on registered count.

## Test plan
- Single frame, FSCLK toggling each cycle, i_ready = 1. FSDO bits 0,1,0,1,0,0,1,0,1,1 (start, 0xA5 LSB-first, channel 1) → o_valid high 1 cycle after the CHAN sample, o_data = 0xA5, o_channel = 1. Pop that same cycle, then o_valid = 0.
- DEPTH = 4, i_ready = 0, send 0x01, 0x02, 0x03, 0x04 → count 4, head 0x01, o_overrun never asserted.
  - Send fifth frame 0x3C → o_overrun single-cycle pulse, FIFO unchanged.
  - Drain → 0x01..0x04 in order, then o_valid = 0.
- FSDO held 1 for 200 cycles with FSCLK running → o_busy = 0, o_valid = 0 throughout.
- Assert i_arst after 5 data bits of a frame, with one word already queued → all outputs at reset values. After release, frame 0x5A, channel 0 → o_data = 0x5A, o_channel = 0, no stale word.
- Hold i_fsclk low for 30 cycles after bit 4 of frame 0xC3, then resume → o_data = 0xC3 and o_busy stays high during the stall.
- count = 1, frame 0x77 completes in the same cycle as a pop of the head → count stays 1, head becomes 0x77, no o_overrun.
